// File: rtl/mem_instr_pipe.sv
// Pipelined instruction memory for the RiSC-16 fetch path.
// Fixed-latency read pipe with back-pressure, flush and a load port.
module mem_instr_pipe #(
  parameter int WORD_LEN = 16,
  parameter int ADDR_LEN = 16,
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_LEN-1:0] req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORD_LEN-1:0] resp_data,
  output logic                resp_err,
  input  logic                flush,
  input  logic                load_en,
  input  logic [ADDR_LEN-1:0] load_addr,
  input  logic [WORD_LEN-1:0] load_data,
  output logic                busy
);

  localparam int IDX_LEN = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_LEN:0] LIMIT = DEPTH[ADDR_LEN:0];

  logic [WORD_LEN-1:0] mem [DEPTH];

  logic [LATENCY-1:0]  stg_v;
  logic [LATENCY-1:0]  stg_e;
  logic [WORD_LEN-1:0] stg_d [LATENCY];

  logic                adv;
  logic                accept;
  logic                req_hit;
  logic                load_hit;
  logic [WORD_LEN-1:0] rd_word;

  assign adv       = !stg_v[LATENCY-1] | resp_ready;
  assign req_ready = rst & adv & !load_en;
  assign accept    = req_valid & req_ready;

  assign req_hit  = {1'b0, req_addr} < LIMIT;
  assign load_hit = {1'b0, load_addr} < LIMIT;

  // Out-of-range fetches read as zero.
  assign rd_word = req_hit ? mem[req_addr[IDX_LEN-1:0]] : '0;

  // Word array: cleared to NOP on reset, written by the load port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load_en && load_hit) begin
      mem[load_addr[IDX_LEN-1:0]] <= load_data;
    end
  end

  // Stage shift register; flush drops in-flight words but keeps
  // the redirected fetch accepted on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_v <= '0;
      stg_e <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_d[i] <= '0;
      end
    end else begin
      if (adv) begin
        stg_v[0] <= accept;
        stg_e[0] <= accept & !req_hit;
        stg_d[0] <= accept ? rd_word : '0;
        for (int i = 1; i < LATENCY; i++) begin
          stg_v[i] <= stg_v[i-1];
          stg_e[i] <= stg_e[i-1];
          stg_d[i] <= stg_d[i-1];
        end
      end
      if (flush) begin
        stg_v    <= '0;
        stg_v[0] <= accept;
      end
    end
  end

  // Response comes straight from the last stage register.
  assign resp_valid = stg_v[LATENCY-1];
  assign resp_data  = stg_d[LATENCY-1];
  assign resp_err   = stg_e[LATENCY-1];
  assign busy       = |stg_v;

endmodule
